// File: rtl/alarm_scheduler.sv
// alarm_scheduler: shares the single speaker between four alarm slots and the
// hourly chime. Slots are matched against the running seconds count on each
// 1 Hz tick, queued in a pending mask and served lowest-index first.
// Optional feature: define ALARM_SNOOZE_EN to build per-slot snooze counters;
// without it the snooze button behaves exactly like dismiss.
module alarm_scheduler #(
  parameter int SEC_W       = 17,
  parameter int CHIME_SECS  = 2,
  parameter int SNOOZE_SECS = 300
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic [SEC_W-1:0] cur_secs,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_slot,
  input  logic             cfg_en,
  input  logic [1:0]       cfg_len,
  input  logic [1:0]       cfg_music,
  input  logic [SEC_W-1:0] cfg_secs,
  input  logic             hour_req,
  input  logic             dismiss,
  input  logic             snooze,
  output logic             ring,
  output logic [1:0]       ring_slot,
  output logic [1:0]       ring_music,
  output logic             chime,
  output logic [3:0]       pending,
  output logic [3:0]       slot_en,
  output logic [5:0]       remaining
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHIME = 2'd1,
    S_RING  = 2'd2
  } state_t;

  localparam logic [5:0] CHIME_LOAD = 6'(CHIME_SECS);

  // The snooze counters are 9 bits wide, so the delay must fit in them.
  if (SNOOZE_SECS < 1 || SNOOZE_SECS > 511) begin : g_bad_snooze_secs
    $error("SNOOZE_SECS must be in 1..511");
  end

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       en_q;
  logic [1:0]       len_q   [4];
  logic [1:0]       music_q [4];
  logic [SEC_W-1:0] secs_q  [4];
  logic             chime_pend;
  logic             chime_take;
  logic [1:0]       grant;
  logic [1:0]       slot_nxt;
  logic [5:0]       rem_nxt;
  logic [3:0]       match_set;
  logic [3:0]       cfg_clr;
  logic [3:0]       ring_clr;
  logic [3:0]       slot_oh;
  logic [3:0]       snz_fire;
  logic             abort;
  logic             stop_evt;

  // Ring length in ticks for each length code.
  function automatic logic [5:0] ring_len(input logic [1:0] code);
    case (code)
      2'd0:    ring_len = 6'd15;
      2'd1:    ring_len = 6'd30;
      2'd2:    ring_len = 6'd45;
      default: ring_len = 6'd60;
    endcase
  endfunction

  assign cfg_clr  = (cfg_we && !cfg_en) ? (4'b0001 << cfg_slot) : 4'b0000;
  assign abort    = (state == S_RING) && cfg_we && !cfg_en && (cfg_slot == ring_slot);
  assign slot_oh  = 4'b0001 << ring_slot;

`ifdef ALARM_SNOOZE_EN
  assign stop_evt = dismiss;
`else
  assign stop_evt = dismiss | snooze;
`endif

  // Slot configuration registers; one write updates every field of a slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        len_q[i]   <= 2'd0;
        music_q[i] <= 2'd0;
        secs_q[i]  <= '0;
      end
    end else if (cfg_we) begin
      en_q[cfg_slot]    <= cfg_en;
      len_q[cfg_slot]   <= cfg_len;
      music_q[cfg_slot] <= cfg_music;
      secs_q[cfg_slot]  <= cfg_secs;
    end
  end

  // Exact time-of-day match on the tick for every enabled slot.
  always_comb begin
    match_set = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (tick_1hz && en_q[i] && (secs_q[i] == cur_secs)) match_set[i] = 1'b1;
    end
  end

  // Lowest-index pending slot wins the speaker.
  always_comb begin
    grant = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) grant = 2'(i);
    end
  end

`ifdef ALARM_SNOOZE_EN
  localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SECS);

  logic [8:0] snz_cnt [4];
  logic [3:0] snz_act;
  logic [3:0] snz_load;
  logic [3:0] snz_cancel;

  // A snoozed slot re-queues itself on the tick that exhausts its counter.
  always_comb begin
    snz_fire = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (snz_act[i] && tick_1hz && (snz_cnt[i] == 9'd1) && !cfg_clr[i]) snz_fire[i] = 1'b1;
    end
  end

  // Per-slot snooze countdowns: cancel beats load, load beats counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snz_act <= 4'b0000;
      for (int i = 0; i < 4; i++) snz_cnt[i] <= 9'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cfg_clr[i] || snz_cancel[i]) begin
          snz_act[i] <= 1'b0;
        end else if (snz_load[i]) begin
          snz_act[i] <= 1'b1;
          snz_cnt[i] <= SNOOZE_LOAD;
        end else if (snz_act[i] && tick_1hz) begin
          if (snz_cnt[i] == 9'd1) snz_act[i] <= 1'b0;
          snz_cnt[i] <= snz_cnt[i] - 9'd1;
        end
      end
    end
  end
`else
  assign snz_fire = 4'b0000;
`endif

  // Next-state logic: chime has priority out of IDLE, rings run to timeout or stop.
  always_comb begin
    state_nxt  = state;
    rem_nxt    = remaining;
    slot_nxt   = ring_slot;
    ring_clr   = 4'b0000;
    chime_take = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz_load   = 4'b0000;
    snz_cancel = 4'b0000;
`endif
    case (state)
      S_IDLE: begin
        if (chime_pend || hour_req) begin
          chime_take = 1'b1;
          rem_nxt    = CHIME_LOAD;
          state_nxt  = S_CHIME;
        end else if (pending != 4'b0000) begin
          slot_nxt  = grant;
          rem_nxt   = ring_len(len_q[grant]);
          state_nxt = S_RING;
        end
      end
      S_CHIME: begin
        if (stop_evt || (tick_1hz && remaining <= 6'd1)) begin
          rem_nxt   = 6'd0;
          state_nxt = S_IDLE;
        end else if (tick_1hz) begin
          rem_nxt = remaining - 6'd1;
        end
      end
      S_RING: begin
        if (abort) begin
          rem_nxt   = 6'd0;
          state_nxt = S_IDLE;
        end else if (stop_evt) begin
          rem_nxt   = 6'd0;
          ring_clr  = slot_oh;
          state_nxt = S_IDLE;
`ifdef ALARM_SNOOZE_EN
          snz_cancel = slot_oh;
`endif
        end
`ifdef ALARM_SNOOZE_EN
        else if (snooze) begin
          rem_nxt   = 6'd0;
          ring_clr  = slot_oh;
          snz_load  = slot_oh;
          state_nxt = S_IDLE;
        end
`endif
        else if (tick_1hz && remaining <= 6'd1) begin
          rem_nxt   = 6'd0;
          ring_clr  = slot_oh;
          state_nxt = S_IDLE;
        end else if (tick_1hz) begin
          rem_nxt = remaining - 6'd1;
        end
      end
      default: begin
        rem_nxt   = 6'd0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, queue and chime latch; a match set outranks a ring-end clear, a disable outranks all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      remaining  <= 6'd0;
      ring_slot  <= 2'd0;
      chime_pend <= 1'b0;
      pending    <= 4'b0000;
    end else begin
      state      <= state_nxt;
      remaining  <= rem_nxt;
      ring_slot  <= slot_nxt;
      chime_pend <= (chime_pend | hour_req) & ~chime_take;
      pending    <= ((pending & ~ring_clr) | match_set | snz_fire) & ~cfg_clr;
    end
  end

  assign ring       = (state == S_RING);
  assign chime      = (state == S_CHIME);
  assign ring_music = music_q[ring_slot];
  assign slot_en    = en_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// tb_alarm_scheduler: directed scenarios with literal expectations, then a
// randomized run; a spec-level model is compared against the DUT every cycle.
module tb_alarm_scheduler;

  localparam int SEC_W       = 17;
  localparam int CHIME_SECS  = 2;
  localparam int SNOOZE_SECS = 300;
  localparam int MODE_IDLE   = 0;
  localparam int MODE_CHIME  = 1;
  localparam int MODE_RING   = 2;

  logic             clk       = 1'b0;
  logic             rst       = 1'b0;
  logic             tick_1hz  = 1'b0;
  logic [SEC_W-1:0] cur_secs  = '0;
  logic             cfg_we    = 1'b0;
  logic [1:0]       cfg_slot  = 2'd0;
  logic             cfg_en    = 1'b0;
  logic [1:0]       cfg_len   = 2'd0;
  logic [1:0]       cfg_music = 2'd0;
  logic [SEC_W-1:0] cfg_secs  = '0;
  logic             hour_req  = 1'b0;
  logic             dismiss   = 1'b0;
  logic             snooze    = 1'b0;
  logic             ring;
  logic [1:0]       ring_slot;
  logic [1:0]       ring_music;
  logic             chime;
  logic [3:0]       pending;
  logic [3:0]       slot_en;
  logic [5:0]       remaining;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  typedef struct {
    logic             tick;
    logic [SEC_W-1:0] cur;
    logic             we;
    logic [1:0]       slot;
    logic             en;
    logic [1:0]       len;
    logic [1:0]       music;
    logic [SEC_W-1:0] secs;
    logic             hour;
    logic             dis;
    logic             snz;
  } stim_t;

  alarm_scheduler #(
    .SEC_W(SEC_W),
    .CHIME_SECS(CHIME_SECS),
    .SNOOZE_SECS(SNOOZE_SECS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick_1hz(tick_1hz),
    .cur_secs(cur_secs),
    .cfg_we(cfg_we),
    .cfg_slot(cfg_slot),
    .cfg_en(cfg_en),
    .cfg_len(cfg_len),
    .cfg_music(cfg_music),
    .cfg_secs(cfg_secs),
    .hour_req(hour_req),
    .dismiss(dismiss),
    .snooze(snooze),
    .ring(ring),
    .ring_slot(ring_slot),
    .ring_music(ring_music),
    .chime(chime),
    .pending(pending),
    .slot_en(slot_en),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  // Behavioural model state: what the speaker should be doing and what is queued.
  int               m_mode  = MODE_IDLE;
  logic [1:0]       m_slot  = 2'd0;
  int               m_left  = 0;
  logic [3:0]       m_pend  = 4'b0000;
  bit               m_cpend = 1'b0;
  bit               m_en    [4];
  logic [1:0]       m_len   [4];
  logic [1:0]       m_music [4];
  logic [SEC_W-1:0] m_secs  [4];
`ifdef ALARM_SNOOZE_EN
  int               m_snz   [4];
`endif

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_mode  = MODE_IDLE;
    m_slot  = 2'd0;
    m_left  = 0;
    m_pend  = 4'b0000;
    m_cpend = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_en[i] = 1'b0; m_len[i] = 2'd0; m_music[i] = 2'd0; m_secs[i] = '0;
`ifdef ALARM_SNOOZE_EN
      m_snz[i] = 0;
`endif
    end
  endtask

  task automatic modelStep();
    logic [3:0] set_b = 4'b0000;
    logic [3:0] clr_b = 4'b0000;
    logic [3:0] off_b = 4'b0000;
    bit stop;
`ifdef ALARM_SNOOZE_EN
    logic [3:0] load_b = 4'b0000;
    logic [3:0] cancel_b = 4'b0000;
    stop = dismiss;
`else
    stop = dismiss || snooze;
`endif
    if (cfg_we && !cfg_en) off_b[cfg_slot] = 1'b1;
    for (int i = 0; i < 4; i++)
      if (tick_1hz && m_en[i] && m_secs[i] == cur_secs) set_b[i] = 1'b1;
`ifdef ALARM_SNOOZE_EN
    for (int i = 0; i < 4; i++)
      if (tick_1hz && m_snz[i] == 1 && !off_b[i]) set_b[i] = 1'b1;
`endif
    if (m_mode == MODE_IDLE) begin
      if (m_cpend || hour_req) begin
        m_mode = MODE_CHIME; m_left = CHIME_SECS; m_cpend = 1'b0;
      end else if (m_pend != 4'b0000) begin
        for (int i = 3; i >= 0; i--) if (m_pend[i]) m_slot = 2'(i);
        m_left = 15 * (int'(m_len[m_slot]) + 1);
        m_mode = MODE_RING;
      end
    end else begin
      if (hour_req) m_cpend = 1'b1;
      if (m_mode == MODE_CHIME) begin
        if (stop || (tick_1hz && m_left <= 1)) begin m_mode = MODE_IDLE; m_left = 0; end
        else if (tick_1hz) m_left--;
      end else if (cfg_we && !cfg_en && cfg_slot == m_slot) begin
        m_mode = MODE_IDLE; m_left = 0;
      end else if (stop) begin
        m_mode = MODE_IDLE; m_left = 0; clr_b[m_slot] = 1'b1;
`ifdef ALARM_SNOOZE_EN
        cancel_b[m_slot] = 1'b1;
      end else if (snooze) begin
        m_mode = MODE_IDLE; m_left = 0; clr_b[m_slot] = 1'b1; load_b[m_slot] = 1'b1;
`endif
      end else if (tick_1hz && m_left <= 1) begin
        m_mode = MODE_IDLE; m_left = 0; clr_b[m_slot] = 1'b1;
      end else if (tick_1hz) begin
        m_left--;
      end
    end
`ifdef ALARM_SNOOZE_EN
    for (int i = 0; i < 4; i++) begin
      if (off_b[i] || cancel_b[i]) m_snz[i] = 0;
      else if (load_b[i]) m_snz[i] = SNOOZE_SECS;
      else if (m_snz[i] > 0 && tick_1hz) m_snz[i]--;
    end
`endif
    m_pend = ((m_pend & ~clr_b) | set_b) & ~off_b;
    if (cfg_we) begin
      m_en[cfg_slot] = cfg_en; m_len[cfg_slot] = cfg_len;
      m_music[cfg_slot] = cfg_music; m_secs[cfg_slot] = cfg_secs;
    end
  endtask

  // Advance the model on every active edge, and reset it with the DUT.
  always @(posedge clk or negedge rst) begin
    if (!rst) modelReset();
    else modelStep();
  end

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("ring", 32'(ring), 32'(m_mode == MODE_RING));
      checkOutput("chime", 32'(chime), 32'(m_mode == MODE_CHIME));
      checkOutput("ring_slot", 32'(ring_slot), 32'(m_slot));
      checkOutput("ring_music", 32'(ring_music), 32'(m_music[m_slot]));
      checkOutput("pending", 32'(pending), 32'(m_pend));
      checkOutput("slot_en", 32'(slot_en), 32'({m_en[3], m_en[2], m_en[1], m_en[0]}));
      checkOutput("remaining", 32'(remaining), 32'(m_left));
    end
  end

  function automatic stim_t idleStim();
    stim_t s;
    s.tick = 1'b0; s.cur = '0; s.we = 1'b0; s.slot = 2'd0; s.en = 1'b0;
    s.len = 2'd0; s.music = 2'd0; s.secs = '0; s.hour = 1'b0; s.dis = 1'b0; s.snz = 1'b0;
    return s;
  endfunction

  function automatic stim_t tickStim(input int secs);
    stim_t s = idleStim();
    s.tick = 1'b1; s.cur = SEC_W'(secs);
    return s;
  endfunction

  function automatic stim_t cfgStim(input int slot, input bit en, input int len, input int music, input int secs);
    stim_t s = idleStim();
    s.we = 1'b1; s.slot = 2'(slot); s.en = en; s.len = 2'(len); s.music = 2'(music); s.secs = SEC_W'(secs);
    return s;
  endfunction

  function automatic stim_t pulseStim(input bit hour, input bit dis, input bit snz);
    stim_t s = idleStim();
    s.hour = hour; s.dis = dis; s.snz = snz;
    return s;
  endfunction

  function automatic int pickSecs();
    int r = int'($urandom_range(0, 4));
    if (r == 4) return int'($urandom_range(0, 86399));
    return 100 * (r + 1);
  endfunction

  // Drive one cycle of inputs, let one active edge pass, then sample point is edge+1.
  task automatic applyStimulus(input stim_t s);
    tick_1hz = s.tick; cur_secs = s.cur; cfg_we = s.we; cfg_slot = s.slot; cfg_en = s.en;
    cfg_len = s.len; cfg_music = s.music; cfg_secs = s.secs;
    hour_req = s.hour; dismiss = s.dis; snooze = s.snz;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; cfg_we = 1'b0; hour_req = 1'b0; dismiss = 1'b0; snooze = 1'b0;
  endtask

  initial begin
    stim_t s;
    int    r;
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ring", 32'(ring), 32'd0);
    checkOutput("reset chime", 32'(chime), 32'd0);
    checkOutput("reset pending", 32'(pending), 32'd0);
    checkOutput("reset slot_en", 32'(slot_en), 32'd0);
    checkOutput("reset remaining", 32'(remaining), 32'd0);
    checkOutput("reset ring_slot", 32'(ring_slot), 32'd0);
    rst = 1'b1;
    cmp_en = 1'b1;

    // Single match on slot 1, 15-tick ring.
    applyStimulus(cfgStim(1, 1'b1, 0, 2, 100));
    checkOutput("cfg slot_en", 32'(slot_en), 32'b0010);
    applyStimulus(tickStim(100));
    checkOutput("match pending", 32'(pending), 32'b0010);
    checkOutput("match ring early", 32'(ring), 32'd0);
    applyStimulus(idleStim());
    checkOutput("match ring", 32'(ring), 32'd1);
    checkOutput("match ring_slot", 32'(ring_slot), 32'd1);
    checkOutput("match ring_music", 32'(ring_music), 32'd2);
    checkOutput("match remaining", 32'(remaining), 32'd15);
    for (int k = 0; k < 14; k++) applyStimulus(tickStim(0));
    checkOutput("ring after 14 ticks", 32'(ring), 32'd1);
    checkOutput("remaining after 14 ticks", 32'(remaining), 32'd1);
    applyStimulus(tickStim(0));
    checkOutput("ring after 15 ticks", 32'(ring), 32'd0);
    checkOutput("pending after timeout", 32'(pending), 32'd0);

    // Two slots match together: slot 0 first, one-cycle gap, then slot 2.
    applyStimulus(cfgStim(0, 1'b1, 1, 1, 200));
    applyStimulus(cfgStim(2, 1'b1, 0, 2, 200));
    applyStimulus(tickStim(200));
    checkOutput("queue pending", 32'(pending), 32'b0101);
    applyStimulus(idleStim());
    checkOutput("queue first slot", 32'(ring_slot), 32'd0);
    checkOutput("queue first remaining", 32'(remaining), 32'd30);
    applyStimulus(pulseStim(1'b0, 1'b1, 1'b0));
    checkOutput("queue gap ring", 32'(ring), 32'd0);
    checkOutput("queue gap pending", 32'(pending), 32'b0100);
    applyStimulus(idleStim());
    checkOutput("queue second ring", 32'(ring), 32'd1);
    checkOutput("queue second slot", 32'(ring_slot), 32'd2);
    checkOutput("queue second music", 32'(ring_music), 32'd2);
    applyStimulus(pulseStim(1'b0, 1'b1, 1'b0));

    // Chime requested during a ring waits for the ring to end.
    applyStimulus(cfgStim(3, 1'b1, 0, 0, 300));
    applyStimulus(tickStim(300));
    applyStimulus(idleStim());
    checkOutput("defer ring slot3", 32'(ring_slot), 32'd3);
    applyStimulus(pulseStim(1'b1, 1'b0, 1'b0));
    checkOutput("defer chime held", 32'(chime), 32'd0);
    applyStimulus(pulseStim(1'b0, 1'b1, 1'b0));
    checkOutput("defer chime at gap", 32'(chime), 32'd0);
    applyStimulus(idleStim());
    checkOutput("defer chime on", 32'(chime), 32'd1);
    checkOutput("defer chime remaining", 32'(remaining), 32'd2);
    applyStimulus(tickStim(0));
    checkOutput("chime after 1 tick", 32'(chime), 32'd1);
    applyStimulus(tickStim(0));
    checkOutput("chime after 2 ticks", 32'(chime), 32'd0);

    // Disabling the ringing slot aborts the ring.
    applyStimulus(tickStim(100));
    applyStimulus(idleStim());
    checkOutput("abort ring on", 32'(ring), 32'd1);
    applyStimulus(cfgStim(1, 1'b0, 0, 2, 100));
    checkOutput("abort ring off", 32'(ring), 32'd0);
    checkOutput("abort pending", 32'(pending), 32'd0);
    checkOutput("abort slot_en", 32'(slot_en), 32'b1101);

    // Snooze during a ring.
    applyStimulus(cfgStim(1, 1'b1, 0, 2, 100));
    applyStimulus(tickStim(100));
    applyStimulus(idleStim());
    applyStimulus(pulseStim(1'b0, 1'b0, 1'b1));
    checkOutput("snooze ring off", 32'(ring), 32'd0);
`ifdef ALARM_SNOOZE_EN
    for (int k = 0; k < SNOOZE_SECS - 1; k++) applyStimulus(tickStim(0));
    checkOutput("snooze not yet", 32'(pending), 32'd0);
    applyStimulus(tickStim(0));
    checkOutput("snooze requeue", 32'(pending), 32'b0010);
    applyStimulus(idleStim());
    checkOutput("snooze re-ring", 32'(ring), 32'd1);
    applyStimulus(pulseStim(1'b0, 1'b1, 1'b0));
`else
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    checkOutput("snooze no re-ring", 32'(ring), 32'd0);
    checkOutput("snooze pending", 32'(pending), 32'd0);
`endif

    // Asynchronous reset in the middle of a ring.
    applyStimulus(tickStim(200));
    applyStimulus(idleStim());
    checkOutput("pre-reset ring", 32'(ring), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async reset ring", 32'(ring), 32'd0);
    checkOutput("async reset pending", 32'(pending), 32'd0);
    checkOutput("async reset slot_en", 32'(slot_en), 32'd0);
    #1 rst = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      s = idleStim();
      if (c % 3 == 0) begin
        s.tick = 1'b1;
        s.cur = SEC_W'(pickSecs());
      end
      r = int'($urandom_range(0, 999));
      if (r < 20) begin
        s.we = 1'b1; s.slot = 2'($urandom_range(0, 3)); s.en = ($urandom_range(0, 3) != 0);
        s.len = 2'($urandom_range(0, 3)); s.music = 2'($urandom_range(0, 2)); s.secs = SEC_W'(pickSecs());
      end
      s.hour = ($urandom_range(0, 299) == 0);
      s.dis  = ($urandom_range(0, 149) == 0);
      s.snz  = ($urandom_range(0, 249) == 0);
      if (c == 3000) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
      applyStimulus(s);
    end

    applyStimulus(idleStim());
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Arbitrates the single speaker output among four alarm slots and the hourly chime. It holds the slot configuration (enable, time, length, music) and detects matches against the running seconds count on each 1 Hz strobe. Matched alarms are queued and served one at a time, each for its programmed length, until the alarm times out or the user dismisses it. It sits between the core seconds counter, the alarm-setting UI, the hour-check block and the song players.

## Interface
Parameters:
- SEC_W, 17, width of seconds-of-day values
- CHIME_SECS, 2, chime duration in ticks
- SNOOZE_SECS, 300, snooze delay in ticks (used only with ALARM_SNOOZE_EN)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- tick_1hz  in  1  one-cycle strobe, once per second, synchronous to clk
- cur_secs  in  SEC_W  current seconds of day, 0..86399
- cfg_we  in  1  one-cycle configuration write strobe
- cfg_slot  in  2  slot index written
- cfg_en  in  1  slot enable
- cfg_len  in  2  length code: 0→15 s, 1→30 s, 2→45 s, 3→60 s
- cfg_music  in  2  song select, 0..2
- cfg_secs  in  SEC_W  alarm time, seconds of day
- hour_req  in  1  one-cycle chime request from hour check
- dismiss  in  1  debounced one-cycle button pulse
- snooze  in  1  debounced one-cycle button pulse
- ring  out  1  alarm song player enable
- ring_slot  out  2  slot being served
- ring_music  out  2  cfg_music of ring_slot
- chime  out  1  chime active
- pending  out  4  queued slots
- slot_en  out  4  per-slot enable, for display
- remaining  out  6  ticks left in the current ring or chime

## Operation
- Configuration registers: per slot en, len, music, and secs. cfg_we writes all four fields for cfg_slot.
  - A write with cfg_en=0 clears pending[cfg_slot].
  - If that slot is currently ringing, the same write also aborts the ring and the FSM returns to IDLE.
  - A write with cfg_en=1 to the ringing slot leaves the ring and its remaining count unchanged; the new len applies from the next ring.
- Match: on a cycle with tick_1hz=1, every slot with en=1 and secs==cur_secs sets its pending bit. Detection is equality only. Seconds wrap is handled by the seconds counter upstream.
- Chime latch: hour_req sets chime_pend, and chime_pend holds until the chime is served.
- FSM states:
  - IDLE:
    - If chime_pend is set: clear chime_pend, load remaining=CHIME_SECS, go to CHIME.
    - Otherwise, if pending≠0: grant the lowest-index pending slot, latch ring_slot, load remaining from len (15/30/45/60), go to RING.
  - CHIME: chime=1. Each tick decrements remaining. At 0, or on dismiss, go to IDLE.
  - RING: ring=1. Each tick decrements remaining.
    - When remaining reaches 0, or on dismiss: clear pending[ring_slot], go to IDLE.
    - hour_req during RING only latches chime_pend; the chime does not preempt the ring.
- dismiss and snooze in IDLE are ignored.
- Simultaneous events:
  - If a match-set and a dismiss-clear hit the same pending bit in the same cycle, the set wins.
  - If hour_req and pending≠0 arrive in the same IDLE cycle, the chime is served first.
- Outputs clear one cycle after leaving a state.
- Reset values: ring=0, chime=0, ring_slot=0, ring_music=0, pending=0, slot_en=0, remaining=0. All slot config registers reset to 0. chime_pend=0, FSM=IDLE.

## Timing
- Tick at cycle t with a match → pending set at t+1 → ring=1 at t+2, if the FSM is IDLE.
- dismiss at cycle t → ring=0 at t+1. The next queued slot is granted at t+2, so ring drops low for at least one cycle between alarms.
- remaining decrements only on tick_1hz cycles. A 15 s alarm therefore rings for 15 ticks, ±1 tick of phase.
- Reset asserted mid-ring clears all outputs immediately (asynchronously).

## Configuration
- ALARM_SNOOZE_EN defined:
  - snooze during RING ends the ring, clears pending[ring_slot] and loads a per-slot 9-bit snooze counter with SNOOZE_SECS.
  - Each counter decrements on tick. On reaching 0 it sets pending for that slot.
  - dismiss or a cfg write with cfg_en=0 cancels the slot's snooze counter.
- ALARM_SNOOZE_EN undefined: no snooze counters are built, and snooze behaves identically to dismiss.

## Test plan
- Match: slot1 config en=1, secs=100, len=0; tick with cur_secs=100 → pending=0010 next cycle, ring=1 with ring_slot=1 two cycles after the tick, ring=0 after 15 ticks, pending=0000.
- Queue: slots 0 and 2 both match at secs=200 → slot0 rings first; dismiss → ring=0 for one cycle, then slot2 rings with ring_music=cfg_music of slot2.
- Chime deferral: hour_req during a slot3 ring → chime=0 until the ring ends; then chime=1 for 2 ticks.
- Config abort: during a slot1 ring, cfg_we with cfg_slot=1, cfg_en=0 → ring=0 next cycle, pending[1]=0.
- Snooze (macro defined): snooze during ring → ring=0; after 300 ticks pending[slot]=1 and the slot rings again. With the macro undefined, snooze → no re-ring.
- Reset: rst=0 mid-ring → ring=0, pending=0, slot_en=0 immediately.
